// File: rtl/serial_subtractor_if.sv
// Operand/result bus of the digit-serial subtractor.
//
// Handshake: the requester holds start high with A/B/Bin valid; the request
// is taken on the rising edge where the engine is IDLE or DONE (otherwise it
// is dropped, never queued). busy is high while slices are being computed,
// done pulses for one cycle when Diff/Borrow/Zero hold the new result, and
// those result fields stay stable until the next operation completes.
interface serial_subtractor_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] Diff;
  logic             Borrow;
  logic             Zero;

  modport master (
    output start, A, B, Bin,
    input  busy, done, Diff, Borrow, Zero
  );

  modport slave (
    input  start, A, B, Bin,
    output busy, done, Diff, Borrow, Zero
  );
endinterface

// File: rtl/serial_subtractor.sv
// Digit-serial unsigned subtractor: Diff = A - B - Bin, DIGIT bits per clock,
// LSB slice first, borrow chained between slices. The result is accumulated
// in a private shift register and committed to the outputs only when the
// last slice is done, so partial results never appear on Diff.
module serial_subtractor #(
  parameter int WIDTH = 8,
  parameter int DIGIT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  serial_subtractor_if.slave  bus,
  output logic [1:0]          fsm_state
);

  localparam int STEPS = WIDTH / DIGIT;
  localparam int CW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [CW-1:0] LAST_CNT = CW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             step;
  logic             last;

  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic             borrow_q;

  logic [DIGIT-1:0] slice;
  logic [DIGIT:0]   chain;
  logic [WIDTH-1:0] res_next;

  assign fsm_state = state;

  // State register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  // Next-state logic: start is only honoured from IDLE or DONE.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (bus.start) state_next = RUN;
      RUN:     if (cnt == LAST_CNT) state_next = DONE;
      DONE:    state_next = bus.start ? RUN : IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM decode: operand capture, slice step, and final-slice strobe.
  always_comb begin
    load = 1'b0;
    step = 1'b0;
    last = 1'b0;
    case (state)
      IDLE, DONE: load = bus.start;
      RUN: begin
        step = 1'b1;
        last = (cnt == LAST_CNT);
      end
      default: ;
    endcase
  end

  // One DIGIT-wide ripple-borrow slice of full subtractors.
  always_comb begin
    chain    = '0;
    slice    = '0;
    chain[0] = borrow_q;
    for (int i = 0; i < DIGIT; i++) begin
      slice[i]   = a_sh[i] ^ b_sh[i] ^ chain[i];
      chain[i+1] = (~a_sh[i] & b_sh[i]) | (~(a_sh[i] ^ b_sh[i]) & chain[i]);
    end
    // New slice enters at the top; after STEPS shifts slice 0 sits at bit 0.
    res_next = (res_sh >> DIGIT) | (WIDTH'(slice) << (WIDTH - DIGIT));
  end

  // Datapath, status flags and result commit.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      a_sh       <= '0;
      b_sh       <= '0;
      res_sh     <= '0;
      borrow_q   <= 1'b0;
      bus.busy   <= 1'b0;
      bus.done   <= 1'b0;
      bus.Diff   <= '0;
      bus.Borrow <= 1'b0;
      bus.Zero   <= 1'b0;
    end else begin
      // Status lags the state by one edge, which places done STEPS+1 edges
      // after acceptance.
      bus.busy <= (state == RUN);
      bus.done <= (state == DONE);
      if (load) begin
        a_sh     <= bus.A;
        b_sh     <= bus.B;
        borrow_q <= bus.Bin;
        res_sh   <= '0;
        cnt      <= '0;
      end else if (step) begin
        a_sh     <= a_sh >> DIGIT;
        b_sh     <= b_sh >> DIGIT;
        borrow_q <= chain[DIGIT];
        res_sh   <= res_next;
        cnt      <= last ? '0 : cnt + 1'b1;
        if (last) begin
          bus.Diff   <= res_next;
          bus.Borrow <= chain[DIGIT];
          bus.Zero   <= (res_next == '0);
        end
      end
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Bench for serial_subtractor: an 8-bit/1-digit and a 16-bit/4-digit instance,
// directed cases plus random operands against an arithmetic reference model.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [1:0] st8;
  logic [1:0] st16;

  int checks   = 0;
  int failures = 0;
  int cur      = 0;  // 0: 8-bit instance, 1: 16-bit instance

  logic [17:0] exp_q[$];  // {borrow, zero, diff}

  serial_subtractor_if #(.WIDTH(8))  bus8 ();
  serial_subtractor_if #(.WIDTH(16)) bus16 ();

  serial_subtractor #(.WIDTH(8), .DIGIT(1)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus8),
    .fsm_state (st8)
  );

  serial_subtractor #(.WIDTH(16), .DIGIT(4)) dut16 (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus16),
    .fsm_state (st16)
  );

  logic        cur_busy;
  logic        cur_done;
  logic        cur_borrow;
  logic        cur_zero;
  logic [15:0] cur_diff;

  assign cur_busy   = (cur == 1) ? bus16.busy   : bus8.busy;
  assign cur_done   = (cur == 1) ? bus16.done   : bus8.done;
  assign cur_borrow = (cur == 1) ? bus16.Borrow : bus8.Borrow;
  assign cur_zero   = (cur == 1) ? bus16.Zero   : bus8.Zero;
  assign cur_diff   = (cur == 1) ? bus16.Diff   : {8'h00, bus8.Diff};

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [15:0] a, input logic [15:0] b, input logic bin, input logic st);
    if (cur == 1) begin
      bus16.A = a; bus16.B = b; bus16.Bin = bin; bus16.start = st;
    end else begin
      bus8.A = a[7:0]; bus8.B = b[7:0]; bus8.Bin = bin; bus8.start = st;
    end
  endtask

  // Reference model: plain integer subtraction, pushed onto the scoreboard.
  task automatic push_expected(input logic [15:0] a, input logic [15:0] b, input logic bin);
    logic [15:0] mask;
    logic [15:0] ed;
    int          full;
    mask = (cur == 1) ? 16'hFFFF : 16'h00FF;
    full = int'(a & mask) - int'(b & mask) - int'(bin);
    ed   = 16'(full) & mask;
    exp_q.push_back({(full < 0), (ed == 16'h0), ed});
  endtask

  task automatic check_result(input string tag);
    logic [17:0] e;
    e = exp_q.pop_front();
    check_val({tag, "_diff"},   32'(cur_diff),   32'(e[15:0]));
    check_val({tag, "_borrow"}, 32'(cur_borrow), 32'(e[17]));
    check_val({tag, "_zero"},   32'(cur_zero),   32'(e[16]));
  endtask

  // Full operation: latency, busy length, result, single done pulse.
  // poke_at > 0 re-pulses start with other operands during RUN.
  task automatic do_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                       input logic bin, input int poke_at);
    int steps;
    int edges;
    int busy_cnt;
    int extra;
    bit got;
    steps = (cur == 1) ? 4 : 8;
    push_expected(a, b, bin);
    drive(a, b, bin, 1'b1);
    @(posedge clk); #1;
    // Operand changes after acceptance must not matter.
    drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    edges = 0; busy_cnt = 0; got = 0;
    while (!got && edges < 100) begin
      @(posedge clk); #1;
      edges++;
      if (cur_busy) busy_cnt++;
      if (cur_done) got = 1;
      if (poke_at != 0 && edges == poke_at) drive(16'hFFFF, 16'h0001, 1'b0, 1'b1);
      else drive(16'($urandom), 16'($urandom), 1'($urandom), 1'b0);
    end
    check_val({tag, "_done_seen"}, 32'(got), 32'd1);
    check_val({tag, "_latency"}, 32'(edges), 32'(steps + 1));
    check_val({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(steps));
    check_result(tag);
    extra = 0;
    repeat (steps + 3) begin
      @(posedge clk); #1;
      if (cur_done) extra++;
    end
    check_val({tag, "_extra_done"}, 32'(extra), 32'd0);
  endtask

  initial begin
    int pulses;
    int edges;
    bit got;

    bus8.start = 0;  bus8.A = 0;  bus8.B = 0;  bus8.Bin = 0;
    bus16.start = 0; bus16.A = 0; bus16.B = 0; bus16.Bin = 0;

    // Reset.
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_val("rst8_busy", 32'(bus8.busy), 0);
    check_val("rst8_done", 32'(bus8.done), 0);
    check_val("rst8_diff", 32'(bus8.Diff), 0);
    check_val("rst8_flags", {30'd0, bus8.Borrow, bus8.Zero}, 0);
    check_val("rst8_state", 32'(st8), 0);
    check_val("rst16_diff", 32'(bus16.Diff), 0);
    check_val("rst16_flags", {29'd0, bus16.busy, bus16.Borrow, bus16.Zero}, 0);

    // Directed cases, 8-bit instance.
    cur = 0;
    do_op("d5a_23", 16'h5A, 16'h23, 1'b0, 0);
    do_op("d00_00_b", 16'h00, 16'h00, 1'b1, 0);
    do_op("d7f_eq", 16'h7F, 16'h7F, 1'b0, 0);
    do_op("d7f_eq_b", 16'h7F, 16'h7F, 1'b1, 0);
    do_op("dpoke", 16'h42, 16'h17, 1'b0, 3);
    do_op("d10_20", 16'h10, 16'h20, 1'b0, 0);

    // Reset asserted in the middle of RUN aborts the operation.
    drive(16'h99, 16'h11, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    check_val("abort_busy", 32'(cur_busy), 0);
    check_val("abort_diff", 32'(cur_diff), 0);
    check_val("abort_borrow", 32'(cur_borrow), 0);
    check_val("abort_zero", 32'(cur_zero), 0);
    pulses = 0;
    repeat (12) begin
      @(posedge clk); #1;
      if (cur_done) pulses++;
    end
    check_val("abort_no_done", 32'(pulses), 0);
    do_op("after_abort", 16'hC3, 16'h3C, 1'b1, 0);

    // 16-bit/4-digit instance, back-to-back start in the DONE cycle.
    cur = 1;
    push_expected(16'h1234, 16'h0FFF, 1'b1);
    drive(16'h1234, 16'h0FFF, 1'b1, 1'b1);
    @(posedge clk); #1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    push_expected(16'h0001, 16'h0002, 1'b0);
    drive(16'h0001, 16'h0002, 1'b0, 1'b1);
    @(posedge clk); #1;
    drive(16'h0, 16'h0, 1'b0, 1'b0);
    check_val("b2b_first_done", 32'(cur_done), 1);
    check_result("b2b_first");
    edges = 0; got = 0;
    while (!got && edges < 50) begin
      @(posedge clk); #1;
      edges++;
      if (cur_done) got = 1;
    end
    check_val("b2b_second_seen", 32'(got), 1);
    check_val("b2b_second_latency", 32'(edges), 32'd5);
    check_result("b2b_second");
    repeat (4) @(posedge clk);
    #1;

    do_op("w16_wrap", 16'h0000, 16'hFFFF, 1'b1, 0);
    do_op("w16_poke", 16'h8000, 16'h7FFF, 1'b0, 2);

    // Random operands on both instances, some forced equal.
    for (int k = 0; k < 2; k++) begin
      cur = k;
      for (int n = 0; n < 30; n++) begin
        logic [15:0] ra;
        logic [15:0] rb;
        ra = 16'($urandom);
        rb = ($urandom_range(0, 4) == 0) ? ra : 16'($urandom);
        do_op("rand", ra, rb, 1'($urandom_range(0, 1)), 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
Name: serial_subtractor

Overview:
Multi-cycle, parametrised unsigned subtractor computing Diff = A - B - Bin. It processes DIGIT bits per clock, LSB slice first, and chains the borrow between slices. Operands are captured on a start handshake, and results are held until the next operation. It serves area-constrained datapaths where a full-width combinational subtractor is not wanted.

Parameters:
WIDTH, 8, operand/result width in bits (>=2)
DIGIT, 1, bits processed per cycle; WIDTH must be an integer multiple of DIGIT (1 <= DIGIT <= WIDTH)
STEPS (localparam), WIDTH/DIGIT, number of RUN cycles per operation

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  synchronous active-low reset
start  input  1  request; accepted only when state is IDLE or DONE
A  input  WIDTH  minuend, sampled on the accepting edge
B  input  WIDTH  subtrahend, sampled on the accepting edge
Bin  input  1  borrow-in, sampled on the accepting edge
busy  output  1  high while state is RUN
done  output  1  one-cycle pulse: results valid
Diff  output  WIDTH  (A - B - Bin) mod 2^WIDTH
Borrow  output  1  final borrow-out; 1 iff A < B + Bin
Zero  output  1  1 iff Diff == 0

Behaviour:
- Reset is synchronous only: rst_n sampled low at a rising edge gives state=IDLE, busy=0, done=0, Diff=0, Borrow=0, Zero=0, and clears the slice counter and shift registers.
- States:
  - IDLE: start=1 -> latch A, B, Bin, counter=0 -> RUN; else stay IDLE.
  - RUN: each edge computes one DIGIT-bit slice with ripple-borrow half/full-subtractor logic and the carried borrow, writes it into the result register, then shifts the operands. When counter==STEPS-1 -> DONE; else counter+1.
  - DONE: done=1 for exactly this cycle. start=1 -> latch new operands -> RUN (back-to-back allowed); else -> IDLE.
- Slice order is LSB first. The borrow into slice 0 is the latched Bin. The borrow out of the last slice is Borrow.
- Latency: start sampled at edge E0. busy is high from E0+1 through the cycle after edge E0+STEPS. done is high in the cycle after edge E0+STEPS+1, i.e. done is visible STEPS+1 edges after acceptance.
- Diff, Borrow and Zero are registered. They update only on the transition RUN -> DONE and are stable from then until the next RUN -> DONE transition. Partial results never appear on Diff: accumulate internally and commit at the end.
- start while RUN is ignored and is not queued. Operand changes while RUN have no effect.
- Zero and Borrow are independent. Example: A=B, Bin=1 gives Diff=all-ones, Borrow=1, Zero=0.
- Wrap-around: result is modulo 2^WIDTH and never saturates.
- Reset asserted mid-RUN aborts the operation. Outputs return to reset values and done does not pulse.
- With DIGIT=WIDTH, STEPS=1: one RUN cycle, then DONE.

Test Plan:
- WIDTH=8, DIGIT=1; A=0x5A, B=0x23, Bin=0, start pulse -> busy high for 8 cycles, then done pulse 9 edges after acceptance; Diff=0x37, Borrow=0, Zero=0.
- A=0x10, B=0x20, Bin=0 -> Diff=0xF0, Borrow=1, Zero=0. A=0x00, B=0x00, Bin=1 -> Diff=0xFF, Borrow=1.
- A=0x7F, B=0x7F, Bin=0 -> Diff=0x00, Zero=1, Borrow=0. Repeat with Bin=1 -> Diff=0xFF, Zero=0, Borrow=1.
- start pulsed again 3 cycles into RUN with A=0xFF, B=0x01 -> ignored. Result is from the original operands, and exactly one done pulse occurs.
- rst_n low for one edge at RUN cycle 4 -> next cycle busy=0, Diff=0, Borrow=0, Zero=0, and no done pulse. A fresh start afterwards computes correctly.
- WIDTH=16, DIGIT=4; A=0x1234, B=0x0FFF, Bin=1 -> 4 RUN cycles, Diff=0x0234, Borrow=0. Assert start in the DONE cycle with A=0x0001, B=0x0002 -> back-to-back result Diff=0xFFFF, Borrow=1.
